keypad_emulator: RTL and testbench

KEYPAD_EMULATOR -- requirements
Module: keypad_emulator

---
 rtl/keypad_emulator.sv | 192 +++++++++++++++++++
 tb/tb_keypad_emulator.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_emulator.sv
// Keypad emulator: replays queued key codes onto a 4x4 matrix keypad
// interface. A scanner drives one-hot columns; while a key is "pressed"
// the matching one-hot row is returned combinationally for a fixed
// number of column sweeps, followed by a release gap.
module keypad_emulator #(
    parameter int HOLD_SCANS = 2,
    parameter int GAP_SCANS  = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [3:0] col,
    output logic [3:0] row,
    input  logic       key_valid,
    input  logic [3:0] key_code,
    output logic       key_ready,
    output logic       busy,
    output logic [3:0] cur_key,
    output logic [7:0] keys_sent,
    output logic       overflow
);

    localparam int PTR_W     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W     = $clog2(FIFO_DEPTH + 1);
    localparam int MAX_SCANS = (HOLD_SCANS > GAP_SCANS) ? HOLD_SCANS : GAP_SCANS;
    localparam int SCAN_W    = (MAX_SCANS > 1) ? $clog2(MAX_SCANS) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PRESS = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_next_state;
    logic [3:0]          r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]    r_wr_ptr;
    logic [PTR_W-1:0]    r_rd_ptr;
    logic [CNT_W-1:0]    r_count;
    logic [3:0]          r_key;
    logic [SCAN_W-1:0]   r_scan_cnt;
    logic [7:0]          r_keys_sent;
    logic                r_overflow;

    logic                w_ready;
    logic                w_push;
    logic                w_pop;
    logic                w_tick;
    logic                w_scan_clr;
    logic                w_scan_inc;
    logic                w_press_done;

    // Readiness comes from registered occupancy only, so a pop in the same
    // cycle never makes room for a push into a full FIFO.
    assign w_ready = (r_count != CNT_W'(FIFO_DEPTH));
    assign w_push  = key_valid && w_ready;
    // A scan tick marks the end of one full column sweep.
    assign w_tick  = en && (col == 4'b0001);

    assign key_ready = w_ready;
    assign busy      = (r_state != S_IDLE) || (r_count != CNT_W'(0));
    assign cur_key   = (r_state == S_PRESS) ? r_key : 4'b0000;
    assign keys_sent = r_keys_sent;
    assign overflow  = r_overflow;

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and sequencing strobes; nothing advances while en is low.
    always_comb begin
        w_next_state = r_state;
        w_pop        = 1'b0;
        w_scan_clr   = 1'b0;
        w_scan_inc   = 1'b0;
        w_press_done = 1'b0;
        if (en) begin
            case (r_state)
                S_IDLE: begin
                    if (r_count != CNT_W'(0)) begin
                        w_pop        = 1'b1;
                        w_scan_clr   = 1'b1;
                        w_next_state = S_PRESS;
                    end
                end
                S_PRESS: begin
                    if (w_tick) begin
                        if (r_scan_cnt == SCAN_W'(HOLD_SCANS - 1)) begin
                            w_next_state = S_GAP;
                            w_scan_clr   = 1'b1;
                            w_press_done = 1'b1;
                        end else begin
                            w_scan_inc = 1'b1;
                        end
                    end
                end
                S_GAP: begin
                    if (w_tick) begin
                        if (r_scan_cnt == SCAN_W'(GAP_SCANS - 1)) begin
                            w_next_state = S_IDLE;
                            w_scan_clr   = 1'b1;
                        end else begin
                            w_scan_inc = 1'b1;
                        end
                    end
                end
                default: begin
                    w_next_state = S_IDLE;
                end
            endcase
        end
    end

    // Row response follows col with zero latency; a non-one-hot col can
    // never equal the key's one-hot column, so it always yields 0000.
    always_comb begin
        row = 4'b0000;
        if ((r_state == S_PRESS) && en && (col == (4'b1000 >> r_key[1:0]))) begin
            row = 4'b1000 >> r_key[3:2];
        end
    end

    // FIFO storage; contents need no reset since occupancy guards reads.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= key_code;
        end
    end

    // FIFO pointers and occupancy, pointers wrap at FIFO_DEPTH.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= (r_wr_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Key register loads the FIFO head when a press begins.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_key <= 4'b0000;
        end else if (w_pop) begin
            r_key <= r_mem[r_rd_ptr];
        end
    end

    // Scan counter counts sweeps within PRESS and GAP.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_scan_cnt <= '0;
        end else if (w_scan_clr) begin
            r_scan_cnt <= '0;
        end else if (w_scan_inc) begin
            r_scan_cnt <= r_scan_cnt + SCAN_W'(1);
        end
    end

    // Completed-press counter (saturating) and sticky drop flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_keys_sent <= 8'd0;
            r_overflow  <= 1'b0;
        end else begin
            if (w_press_done && (r_keys_sent != 8'hFF)) begin
                r_keys_sent <= r_keys_sent + 8'd1;
            end
            if (key_valid && !w_ready) begin
                r_overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_keypad_emulator.sv
// Bench for keypad_emulator: stimulus pushes expected key codes into a
// scoreboard queue; a monitor checks every active row against the queue
// head and retires an entry each time keys_sent advances.
module tb_keypad_emulator;

    localparam int HOLD  = 2;
    localparam int GAP   = 2;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [3:0] col;
    logic [3:0] row;
    logic       key_valid;
    logic [3:0] key_code;
    logic       key_ready;
    logic       busy;
    logic [3:0] cur_key;
    logic [7:0] keys_sent;
    logic       overflow;

    int         checks = 0;
    int         errors = 0;
    logic [3:0] exp_q [$];
    bit         rot;

    keypad_emulator #(
        .HOLD_SCANS (HOLD),
        .GAP_SCANS  (GAP),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .col       (col),
        .row       (row),
        .key_valid (key_valid),
        .key_code  (key_code),
        .key_ready (key_ready),
        .busy      (busy),
        .cur_key   (cur_key),
        .keys_sent (keys_sent),
        .overflow  (overflow)
    );

    always #10 clk = ~clk;

    function automatic logic [3:0] oh(input logic [1:0] i);
        return 4'b1000 >> i;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Advance one clock; inputs change 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
        if (rot) col = {col[0], col[3:1]};
    endtask

    task automatic push(input logic [3:0] c, input bit accept);
        key_valid = 1'b1;
        key_code  = c;
        if (accept) exp_q.push_back(c);
        step();
        key_valid = 1'b0;
    endtask

    task automatic wait_idle(input int max, input string name);
        int n;
        n = 0;
        while (busy && n < max) begin
            step();
            n++;
        end
        check({name, "_idle_timeout"}, int'(busy), 0);
    endtask

    task automatic monitor();
        logic [7:0] prev_ks;
        logic [3:0] e;
        int         hits;
        bit         seen;
        prev_ks = 8'd0;
        hits    = 0;
        seen    = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                prev_ks = keys_sent;
                hits    = 0;
                seen    = 1'b0;
            end else begin
                if (row != 4'b0000) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL row_unexpected: got row %b expected 0000", row);
                    end else begin
                        e = exp_q[0];
                        check("press_col_row", int'({col, row}), int'({oh(e[1:0]), oh(e[3:2])}));
                        check("press_cur_key", int'(cur_key), int'(e));
                        hits++;
                        seen = 1'b1;
                    end
                end
                if (keys_sent != prev_ks) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL press_unexpected: got keys_sent %0d with empty queue", keys_sent);
                    end else begin
                        e = exp_q.pop_front();
                        check("press_seen", int'(seen), 1);
                        if (e[1:0] == 2'd3) check("press_hits", hits, HOLD);
                    end
                    prev_ks = keys_sent;
                    hits    = 0;
                    seen    = 1'b0;
                end
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b0;
        en        = 1'b0;
        col       = 4'b0000;
        key_valid = 1'b0;
        key_code  = 4'b0000;
        rot       = 1'b0;
        fork
            monitor();
        join_none

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        check("rst_row",       int'(row),       0);
        check("rst_key_ready", int'(key_ready), 1);
        check("rst_busy",      int'(busy),      0);
        check("rst_cur_key",   int'(cur_key),   0);
        check("rst_keys_sent", int'(keys_sent), 0);
        check("rst_overflow",  int'(overflow),  0);
        rst = 1'b1;

        // Four keys with a rotating scanner
        en  = 1'b1;
        col = 4'b1000;
        rot = 1'b1;
        push(4'b0000, 1'b1);
        push(4'b1001, 1'b1);
        push(4'b0110, 1'b1);
        push(4'b0101, 1'b1);
        wait_idle(400, "t1");
        check("t1_keys_sent", int'(keys_sent), 4);
        check("t1_busy",      int'(busy),      0);
        check("t1_row_idle",  int'(row),       0);

        // Fill while disabled, overflow, then drain
        rot = 1'b0;
        en  = 1'b0;
        col = 4'b0001;
        push(4'b0011, 1'b1);
        push(4'b1100, 1'b1);
        push(4'b0111, 1'b1);
        push(4'b1011, 1'b1);
        check("t2_key_ready_full", int'(key_ready), 0);
        check("t2_busy_full",      int'(busy),      1);
        check("t2_overflow_pre",   int'(overflow),  0);
        push(4'b1110, 1'b0);
        check("t2_overflow",       int'(overflow),  1);
        check("t2_keys_held",      int'(keys_sent), 4);
        check("t2_row_disabled",   int'(row),       0);
        en        = 1'b1;
        key_valid = 1'b1;
        key_code  = 4'b1111;
        step();
        key_valid = 1'b0;
        check("t2_ready_after_pop", int'(key_ready), 1);
        rot = 1'b1;
        wait_idle(400, "t2");
        check("t2_keys_sent",      int'(keys_sent), 8);
        check("t2_overflow_stick", int'(overflow),  1);

        // Key 1111: illegal columns, hold and gap timing
        rot = 1'b0;
        col = 4'b0000;
        push(4'b1111, 1'b1);
        step();
        col = 4'b0110;
        #1 check("t3_col_0110", int'(row), 0);
        col = 4'b0000;
        #1 check("t3_col_0000", int'(row), 0);
        col = 4'b1000;
        #1 check("t3_col_1000", int'(row), 0);
        col = 4'b0001;
        #1 check("t3_col_0001", int'(row), 4'b0001);
        check("t3_cur_key", int'(cur_key), 4'b1111);
        step();
        check("t3_ks_tick1",  int'(keys_sent), 8);
        check("t3_row_tick1", int'(row),       4'b0001);
        step();
        check("t3_ks_tick2",  int'(keys_sent), 9);
        check("t3_row_gap",   int'(row),       0);
        check("t3_busy_gap0", int'(busy),      1);
        step();
        check("t3_busy_gap1", int'(busy),      1);
        step();
        check("t3_busy_gap2", int'(busy),      0);

        // Enable dropped mid-press
        col = 4'b0000;
        push(4'b1011, 1'b1);
        step();
        col = 4'b0001;
        step();
        en = 1'b0;
        #1 check("t4_row_en_low", int'(row), 0);
        repeat (10) step();
        check("t4_cur_key", int'(cur_key),   4'b1011);
        check("t4_row",     int'(row),       0);
        check("t4_ks_held", int'(keys_sent), 9);
        check("t4_busy",    int'(busy),      1);
        en = 1'b1;
        #1 check("t4_row_resume", int'(row), 4'b0010);
        step();
        check("t4_ks_done", int'(keys_sent), 10);
        wait_idle(50, "t4");

        // Reset mid-press with three keys queued
        col = 4'b0000;
        push(4'b0100, 1'b1);
        push(4'b0001, 1'b1);
        push(4'b1010, 1'b1);
        push(4'b1111, 1'b1);
        col = 4'b1000;
        #1 check("t5_row_pre", int'(row), 4'b0100);
        rst = 1'b0;
        exp_q.delete();
        #1;
        check("t5_row",       int'(row),       0);
        check("t5_keys_sent", int'(keys_sent), 0);
        check("t5_key_ready", int'(key_ready), 1);
        check("t5_busy",      int'(busy),      0);
        check("t5_cur_key",   int'(cur_key),   0);
        check("t5_overflow",  int'(overflow),  0);
        step();
        rst = 1'b1;
        rot = 1'b1;
        repeat (40) step();
        check("t5_ks_after",   int'(keys_sent), 0);
        check("t5_busy_after", int'(busy),      0);
        check("queue_drained", exp_q.size(),    0);

        repeat (2) step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
